// File: rtl/cpu_types.sv
// Shared CPU types: reservation-station tags, the INVALID tag and the CDB broadcast record.
package cpu_types;

  localparam int unsigned CDB_NUM_REQ = 4;

  typedef logic [3:0] RS_tag_type;

  localparam RS_tag_type INVALID = 4'h0;

  typedef struct packed {
    RS_tag_type  tag;
    logic [31:0] data;
  } cdb_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: grants the first eligible index at or after ptr_i,
// wrapping from NUM_REQ-1 back to 0.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && elig_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional units, registered broadcast.
// Optional performance counters are enabled by defining CDB_ARB_PERF_EN.
module cdb_arbiter
  import cpu_types::*;
#(
  parameter int unsigned NUM_REQ = CDB_NUM_REQ,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_i,
  input  RS_tag_type [NUM_REQ-1:0] tag_i,
  input  logic [NUM_REQ-1:0][31:0] data_i,
  input  logic                     flush_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output cdb_t                     cdb_o,
  output logic                     cdb_valid_o
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]         conflict_cnt_o,
  output logic [CNT_W-1:0]         bcast_cnt_o
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] elig, pick_elig, pick_gnt;
  logic               pick_valid;
  logic [PTR_W-1:0]   ptr_q, ptr_d, gnt_idx;
  cdb_t               cdb_q, cdb_d;
  logic               cdb_valid_q, cdb_valid_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_i[i] && (tag_i[i] != INVALID);
    end
  end

  // Flush squashes the grant but leaves eligibility (and conflict counting) intact.
  assign pick_elig = flush_i ? '0 : elig;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_picker (
    .elig_i (pick_elig),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_gnt),
    .valid_o(pick_valid)
  );

  assign gnt_o = rst_ni ? pick_gnt : '0;

  always_comb begin
    gnt_idx = '0;
    cdb_d   = '{tag: INVALID, data: '0};
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        gnt_idx = PTR_W'(i);
        cdb_d   = '{tag: tag_i[i], data: data_i[i]};
      end
    end
    cdb_valid_d = pick_valid;
    ptr_d       = ptr_q;
    if (pick_valid) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      cdb_q       <= '{tag: INVALID, data: '0};
      cdb_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_q       <= cdb_d;
      cdb_valid_q <= cdb_valid_d;
    end
  end

  assign cdb_o       = cdb_q;
  assign cdb_valid_o = cdb_valid_q;

`ifdef CDB_ARB_PERF_EN
  logic [CNT_W-1:0] conflict_q, conflict_d, bcast_q, bcast_d;

  always_comb begin
    conflict_d = conflict_q;
    bcast_d    = bcast_q;
    if (($countones(elig) > 1) && (conflict_q != '1)) begin
      conflict_d = conflict_q + 1'b1;
    end
    if (pick_valid && (bcast_q != '1)) begin
      bcast_d = bcast_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= '0;
      bcast_q    <= '0;
    end else begin
      conflict_q <= conflict_d;
      bcast_q    <= bcast_d;
    end
  end

  assign conflict_cnt_o = conflict_q;
  assign bcast_cnt_o    = bcast_q;
`endif

endmodule
